// File: rtl/instr_loader_if.sv
// instr_loader_if
// Groups the loader's byte-stream handshake and its instruction-memory
// write bus.
//
// Byte stream (valid/ready): a byte moves on a rising clock edge where
// byte_valid_i and byte_ready_o are both 1. The source holds
// byte_data_i stable while byte_valid_i is high and the byte has not been
// taken. byte_ready_o never depends on byte_valid_i.
//
// Memory bus: im_we_o is a one-cycle write strobe. im_addr_o and im_data_o
// are valid in that cycle.
//
// Modports:
//   master - the loader: drives ready and the memory bus, samples the stream.
//   slave  - the byte source / memory side: drives the stream, samples the rest.
interface instr_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        im_we_o;
  logic [31:0] im_addr_o;
  logic [31:0] im_data_o;

  modport master (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, im_we_o, im_addr_o, im_data_o
  );

  modport slave (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, im_we_o, im_addr_o, im_data_o
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader
// Boot-time program loader. It receives a framed byte stream and builds
// big-endian 32-bit words from it. It writes those words to consecutive
// instruction-memory addresses. The CPU is held in reset until the complete
// image has arrived and its checksum is correct.
//
// Frame: N_HI N_LO, then 4*N payload bytes (MSB first), then CK.
// CK is the XOR of the payload bytes only.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      begin/restart a load (IDLE or DONE only)
//   bus          byte stream in + instruction-memory write out (master side)
//   cpu_rst_n_o  0 holds the CPU in reset; 1 only in DONE
//   done_o       image loaded and verified
//   err_o        load aborted (oversize count or bad checksum); sticky until rst_i
//   word_cnt_o   words written in the current load
//   state_o      FSM state, for debug
module instr_loader #(
  parameter int DEPTH = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  instr_loader_if.master  bus,
  output logic            cpu_rst_n_o,
  output logic            done_o,
  output logic            err_o,
  output logic [15:0]     word_cnt_o,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_next;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [23:0] asm_q;        // first three bytes of the word being assembled
  logic [1:0]  byte_cnt;
  logic [7:0]  cksum;
  logic [15:0] word_cnt;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_data;

  logic        accept;
  logic [15:0] hdr_n;
  logic        last_word;
  logic        entering_hdr;

  assign accept       = bus.byte_valid_i & bus.byte_ready_o;
  assign hdr_n        = {n_hi, bus.byte_data_i};
  assign last_word    = (16'(word_cnt + 16'd1) == n_words);
  assign entering_hdr = (state_next == ST_HDR_HI) && (state != ST_HDR_HI);

  // Every output below is a decode of registered state or a register.
  assign bus.byte_ready_o = (state == ST_HDR_HI) || (state == ST_HDR_LO) ||
                            (state == ST_DATA)   || (state == ST_CKSUM);
  assign bus.im_we_o      = im_we;
  assign bus.im_addr_o    = im_addr;
  assign bus.im_data_o    = im_data;
  assign cpu_rst_n_o      = (state == ST_DONE);
  assign done_o           = (state == ST_DONE);
  assign err_o            = (state == ST_ERR);
  assign word_cnt_o       = word_cnt;
  assign state_o          = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_i) state_next = ST_HDR_HI;
      ST_HDR_HI: if (accept)  state_next = ST_HDR_LO;
      ST_HDR_LO: if (accept) begin
        if ({1'b0, hdr_n} > DEPTH_W) state_next = ST_ERR;
        else if (hdr_n == 16'd0)     state_next = ST_CKSUM;
        else                         state_next = ST_DATA;
      end
      ST_DATA:   if (accept && (byte_cnt == 2'd3) && last_word) state_next = ST_CKSUM;
      ST_CKSUM:  if (accept) state_next = (bus.byte_data_i == cksum) ? ST_DONE : ST_ERR;
      ST_DONE:   if (start_i) state_next = ST_HDR_HI;
      ST_ERR:    state_next = ST_ERR;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_hi     <= '0;
      n_words  <= '0;
      asm_q    <= '0;
      byte_cnt <= '0;
      cksum    <= '0;
      word_cnt <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_data  <= '0;
    end else begin
      im_we <= 1'b0;
      if (entering_hdr) begin
        word_cnt <= '0;
        byte_cnt <= '0;
        cksum    <= '0;
        asm_q    <= '0;
      end
      if (accept) begin
        case (state)
          ST_HDR_HI: n_hi    <= bus.byte_data_i;
          ST_HDR_LO: n_words <= hdr_n;
          ST_DATA: begin
            cksum    <= cksum ^ bus.byte_data_i;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // The fourth byte completes the word. Issue the write in the next cycle.
              im_we    <= 1'b1;
              im_data  <= {asm_q, bus.byte_data_i};
              im_addr  <= {14'd0, word_cnt, 2'b00};
              word_cnt <= 16'(word_cnt + 16'd1);
            end else begin
              asm_q <= {asm_q[15:0], bus.byte_data_i};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_rst_n;
  logic        done;
  logic        err;
  logic [15:0] word_cnt;
  logic [2:0]  state_dbg;

  instr_loader_if bus_if ();

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .bus         (bus_if.master),
    .cpu_rst_n_o (cpu_rst_n),
    .done_o      (done),
    .err_o       (err),
    .word_cnt_o  (word_cnt),
    .state_o     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Expected writes: {word_cnt after write, byte address, data}
  logic [79:0] exp_q[$];
  logic [31:0] words_q[$];

  always @(negedge clk) begin
    if (!rst && bus_if.im_we_o) begin
      logic [79:0] got;
      logic [79:0] exp;
      got = {word_cnt, bus_if.im_addr_o, bus_if.im_data_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got %h required no write", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL write: got cnt/addr/data %h required %h", got, exp);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus_if.byte_valid_i = 1'b0;
    bus_if.byte_data_i  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns at a negedge. On return the byte has been accepted,
  // and the current cycle is the one after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int guard;
    guard = 0;
    if (throttle) begin
      while ($urandom_range(0, 2) == 0) begin
        bus_if.byte_valid_i = 1'b0;
        @(negedge clk);
      end
    end
    bus_if.byte_valid_i = 1'b1;
    bus_if.byte_data_i  = b;
    while (!bus_if.byte_ready_o) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_timeout: got ready 0 required 1 within 200 cycles");
        bus_if.byte_valid_i = 1'b0;
        return;
      end
    end
    @(negedge clk);
    bus_if.byte_valid_i = 1'b0;
  endtask

  // Builds the frame from words_q and pushes the expected writes.
  // Then it drives the frame. ck_xor corrupts the checksum byte.
  task automatic run_load(input bit do_start, input bit throttle, input logic [7:0] ck_xor);
    logic [7:0]  frame[$];
    logic [7:0]  ck;
    logic [15:0] n;
    n  = 16'(words_q.size());
    ck = 8'h00;
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    for (int k = 0; k < words_q.size(); k++) begin
      for (int j = 3; j >= 0; j--) begin
        logic [7:0] b;
        b = words_q[k][j*8 +: 8];
        frame.push_back(b);
        ck = ck ^ b;
      end
      exp_q.push_back({16'(k + 1), 32'(4 * k), words_q[k]});
    end
    frame.push_back(ck ^ ck_xor);
    if (do_start) pulse_start();
    foreach (frame[i]) send_byte(frame[i], throttle);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp += 8;
    if (bus_if.byte_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b required 0", bus_if.byte_ready_o); end
    if (bus_if.im_we_o !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b required 0", bus_if.im_we_o); end
    if (bus_if.im_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h required 0", bus_if.im_addr_o); end
    if (bus_if.im_data_o !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h required 0", bus_if.im_data_o); end
    if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_cpu_rst_n: got %b required 0", cpu_rst_n); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b required 0", done); end
    if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", err); end
    if (word_cnt !== 16'h0) begin n_err++; $display("FAIL rst_word_cnt: got %0d required 0", word_cnt); end
  endtask

  task automatic test_nominal();
    do_reset();
    words_q = {32'h20080005, 32'h01095020};
    run_load(1'b1, 1'b0, 8'h00);
    n_cmp += 5;
    if (done !== 1'b1) begin n_err++; $display("FAIL nom_done: got %b required 1", done); end
    if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL nom_cpu_rst_n: got %b required 1", cpu_rst_n); end
    if (err !== 1'b0) begin n_err++; $display("FAIL nom_err: got %b required 0", err); end
    if (word_cnt !== 16'd2) begin n_err++; $display("FAIL nom_word_cnt: got %0d required 2", word_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL nom_writes: got %0d missing required 0", exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    words_q = {32'h20080005, 32'h01095020};
    run_load(1'b1, 1'b0, 8'h01);  // CK becomes 0x54
    n_cmp += 4;
    if (err !== 1'b1) begin n_err++; $display("FAIL bad_ck_err: got %b required 1", err); end
    if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL bad_ck_cpu_rst_n: got %b required 0", cpu_rst_n); end
    if (done !== 1'b0) begin n_err++; $display("FAIL bad_ck_done: got %b required 0", done); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL bad_ck_writes: got %0d missing required 0", exp_q.size()); end
    pulse_start();
    @(negedge clk);
    n_cmp += 2;
    if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b required 1", err); end
    if (bus_if.byte_ready_o !== 1'b0) begin n_err++; $display("FAIL err_ready: got %b required 0", bus_if.byte_ready_o); end
  endtask

  task automatic test_oversize(input logic [15:0] n);
    do_reset();
    exp_q.delete();
    pulse_start();
    send_byte(n[15:8], 1'b0);
    send_byte(n[7:0], 1'b0);
    n_cmp += 3;
    if (err !== 1'b1) begin n_err++; $display("FAIL oversize_err n=%0d: got %b required 1", n, err); end
    if (bus_if.byte_ready_o !== 1'b0) begin n_err++; $display("FAIL oversize_ready: got %b required 0", bus_if.byte_ready_o); end
    if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL oversize_cpu_rst_n: got %b required 0", cpu_rst_n); end
    bus_if.byte_valid_i = 1'b1;
    bus_if.byte_data_i  = 8'hA5;
    repeat (4) @(negedge clk);
    bus_if.byte_valid_i = 1'b0;
    n_cmp += 2;
    if (err !== 1'b1) begin n_err++; $display("FAIL oversize_sticky: got %b required 1", err); end
    if (word_cnt !== 16'd0) begin n_err++; $display("FAIL oversize_word_cnt: got %0d required 0", word_cnt); end
  endtask

  task automatic test_throttled();
    do_reset();
    // Hold valid in IDLE. No byte may be taken.
    bus_if.byte_valid_i = 1'b1;
    bus_if.byte_data_i  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_if.byte_ready_o !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b required 0", bus_if.byte_ready_o); end
    end
    words_q = {32'h20080005, 32'h01095020};
    run_load(1'b1, 1'b1, 8'h00);
    n_cmp += 4;
    if (done !== 1'b1) begin n_err++; $display("FAIL thr_done: got %b required 1", done); end
    if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL thr_cpu_rst_n: got %b required 1", cpu_rst_n); end
    if (word_cnt !== 16'd2) begin n_err++; $display("FAIL thr_word_cnt: got %0d required 2", word_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL thr_writes: got %0d missing required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    do_reset();
    words_q = {32'h20080005, 32'h01095020};
    run_load(1'b1, 1'b0, 8'h00);
    n_cmp += 3;
    if (done !== 1'b1) begin n_err++; $display("FAIL midrst_done: got %b required 1", done); end
    if (word_cnt !== 16'd2) begin n_err++; $display("FAIL midrst_word_cnt: got %0d required 2", word_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_writes: got %0d missing required 0", exp_q.size()); end
  endtask

  task automatic test_empty_restart();
    do_reset();
    words_q.delete();
    run_load(1'b1, 1'b0, 8'h00);
    n_cmp += 3;
    if (done !== 1'b1) begin n_err++; $display("FAIL empty_done: got %b required 1", done); end
    if (cpu_rst_n !== 1'b1) begin n_err++; $display("FAIL empty_cpu_rst_n: got %b required 1", cpu_rst_n); end
    if (word_cnt !== 16'd0) begin n_err++; $display("FAIL empty_word_cnt: got %0d required 0", word_cnt); end
    pulse_start();
    n_cmp += 4;
    if (cpu_rst_n !== 1'b0) begin n_err++; $display("FAIL restart_cpu_rst_n: got %b required 0", cpu_rst_n); end
    if (done !== 1'b0) begin n_err++; $display("FAIL restart_done: got %b required 0", done); end
    if (bus_if.byte_ready_o !== 1'b1) begin n_err++; $display("FAIL restart_ready: got %b required 1", bus_if.byte_ready_o); end
    if (word_cnt !== 16'd0) begin n_err++; $display("FAIL restart_word_cnt: got %0d required 0", word_cnt); end
    words_q = {32'hCAFEF00D};
    run_load(1'b0, 1'b0, 8'h00);
    n_cmp += 3;
    if (done !== 1'b1) begin n_err++; $display("FAIL restart_load_done: got %b required 1", done); end
    if (word_cnt !== 16'd1) begin n_err++; $display("FAIL restart_load_word_cnt: got %0d required 1", word_cnt); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL restart_writes: got %0d missing required 0", exp_q.size()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 8; it++) begin
      int  n;
      bit  bad;
      logic [7:0] cx;
      n   = $urandom_range(0, 6);
      bad = ($urandom_range(0, 3) == 0);
      cx  = bad ? 8'($urandom_range(1, 255)) : 8'h00;
      words_q.delete();
      for (int k = 0; k < n; k++) words_q.push_back($urandom);
      run_load(1'b1, $urandom_range(0, 1) == 1, cx);
      n_cmp += 4;
      if (done !== !bad) begin n_err++; $display("FAIL rnd%0d_done: got %b required %b", it, done, !bad); end
      if (err !== bad) begin n_err++; $display("FAIL rnd%0d_err: got %b required %b", it, err, bad); end
      if (word_cnt !== 16'(n)) begin n_err++; $display("FAIL rnd%0d_word_cnt: got %0d required %0d", it, word_cnt, n); end
      if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd%0d_writes: got %0d missing required 0", it, exp_q.size()); end
      if (bad) do_reset();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus_if.byte_valid_i = 1'b0;
    bus_if.byte_data_i  = 8'h00;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_oversize(16'd257);
    test_oversize(16'($urandom_range(DEPTH + 1, 65535)));
    test_throttled();
    test_reset_mid_word();
    test_empty_restart();
    test_random();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
